// File: rtl/plotter_axis_driver.sv
// rtl/plotter_axis_driver.sv - paced X/Y unipolar stepper driver with pen servo PWM.
// Optional half-step drive (8-phase table) when PLOTTER_HALF_STEP_EN is defined.
module plotter_axis_driver #(
  parameter int unsigned STEP_CYCLES   = 200000,
  parameter int unsigned PEN_SETTLE    = 50000000,
  parameter int unsigned PWM_PERIOD    = 2000000,
  parameter int unsigned PEN_UP_HIGH   = 100000,
  parameter int unsigned PEN_DOWN_HIGH = 200000,
  parameter int unsigned POS_MAX       = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_valid,
  input  logic [1:0] dirx,
  input  logic [1:0] diry,
  input  logic       pen_down,
  output logic       step_ready,
  output logic [3:0] coil_x,
  output logic [3:0] coil_y,
  output logic [7:0] pos_x,
  output logic [7:0] pos_y,
  output logic       servo_pwm,
  output logic       limit_hit
);

`ifdef PLOTTER_HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  localparam logic [26:0]     STEP_LAST = 27'(STEP_CYCLES - 1);
  localparam logic [26:0]     SETL_LAST = 27'(PEN_SETTLE - 1);
  localparam logic [26:0]     PWM_LAST  = 27'(PWM_PERIOD - 1);
  localparam logic [26:0]     HI_UP     = 27'(PEN_UP_HIGH);
  localparam logic [26:0]     HI_DOWN   = 27'(PEN_DOWN_HIGH);
  localparam logic [7:0]      POS_LIM   = 8'(POS_MAX);
  localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_PEN_WAIT} state_t;

  state_t          r_state;
  logic [26:0]     r_cnt;
  logic [26:0]     r_pwm_cnt;
  logic [26:0]     r_pwm_hi;
  logic [PH_W-1:0] r_ph_x;
  logic [PH_W-1:0] r_ph_y;
  logic [7:0]      r_pos_x;
  logic [7:0]      r_pos_y;
  logic [3:0]      r_coil_x;
  logic [3:0]      r_coil_y;
  logic            r_pen_q;
  logic            r_limit;
  logic            r_pwm;

  logic [PH_W+8:0] w_nx_x;
  logic [PH_W+8:0] w_nx_y;

  function automatic logic [3:0] coil_of(input logic [PH_W-1:0] ph);
    logic [3:0] c;
    c = 4'b0000;
`ifdef PLOTTER_HALF_STEP_EN
    case (ph)
      3'd0: c = 4'b0001;
      3'd1: c = 4'b0011;
      3'd2: c = 4'b0010;
      3'd3: c = 4'b0110;
      3'd4: c = 4'b0100;
      3'd5: c = 4'b1100;
      3'd6: c = 4'b1000;
      default: c = 4'b1001;
    endcase
`else
    case (ph)
      2'd0: c = 4'b0011;
      2'd1: c = 4'b0110;
      2'd2: c = 4'b1100;
      default: c = 4'b1001;
    endcase
`endif
    return c;
  endfunction

  // Packed result {clipped, next_pos, next_phase}; a clipped axis keeps pos and phase.
  function automatic logic [PH_W+8:0] axis_next(input logic [1:0] dir, input logic [7:0] pos,
                                                 input logic [PH_W-1:0] ph);
    logic [PH_W+8:0] r;
    r = {1'b0, pos, ph};
    if (dir == 2'b01) begin
      if (pos == POS_LIM) r = {1'b1, pos, ph};
      else                r = {1'b0, pos + 8'd1, ph + PH_ONE};
    end else if (dir == 2'b10) begin
      if (pos == 8'd0) r = {1'b1, pos, ph};
      else             r = {1'b0, pos - 8'd1, ph - PH_ONE};
    end
    return r;
  endfunction

  assign w_nx_x = axis_next(dirx, r_pos_x, r_ph_x);
  assign w_nx_y = axis_next(diry, r_pos_y, r_ph_y);

  assign step_ready = (r_state == S_IDLE) && (pen_down == r_pen_q);
  assign coil_x     = r_coil_x;
  assign coil_y     = r_coil_y;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign servo_pwm  = r_pwm;
  assign limit_hit  = r_limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ph_x   <= '0;
      r_ph_y   <= '0;
      r_pos_x  <= '0;
      r_pos_y  <= '0;
      r_coil_x <= coil_of('0);
      r_coil_y <= coil_of('0);
      r_pen_q  <= 1'b0;
      r_limit  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A pen change outranks a pending step; the step waits for the settle.
          if (pen_down != r_pen_q) begin
            r_pen_q <= pen_down;
            r_state <= S_PEN_WAIT;
            r_cnt   <= '0;
          end else if (step_valid) begin
            r_state  <= S_HOLD;
            r_cnt    <= '0;
            r_ph_x   <= w_nx_x[PH_W-1:0];
            r_ph_y   <= w_nx_y[PH_W-1:0];
            r_pos_x  <= w_nx_x[PH_W+7:PH_W];
            r_pos_y  <= w_nx_y[PH_W+7:PH_W];
            r_coil_x <= coil_of(w_nx_x[PH_W-1:0]);
            r_coil_y <= coil_of(w_nx_y[PH_W-1:0]);
            r_limit  <= r_limit | w_nx_x[PH_W+8] | w_nx_y[PH_W+8];
          end
        end
        S_HOLD: begin
          if (r_cnt == STEP_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 27'd1;
          end
        end
        S_PEN_WAIT: begin
          if (r_cnt == SETL_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 27'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // High time is latched only at the period wrap so a pulse is never cut or stretched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwm_cnt <= '0;
      r_pwm_hi  <= HI_UP;
      r_pwm     <= 1'b0;
    end else begin
      r_pwm <= (r_pwm_cnt < r_pwm_hi);
      if (r_pwm_cnt == PWM_LAST) begin
        r_pwm_cnt <= '0;
        r_pwm_hi  <= r_pen_q ? HI_DOWN : HI_UP;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + 27'd1;
      end
    end
  end

endmodule

// File: tb/tb_plotter_axis_driver.sv
// tb/tb_plotter_axis_driver.sv - scoreboard bench for plotter_axis_driver (two position limits).
module tb_plotter_axis_driver;

  localparam int SC = 4;
  localparam int PS = 6;
  localparam int PP = 10;
  localparam int UH = 2;
  localparam int DH = 5;

`ifdef PLOTTER_HALF_STEP_EN
  localparam int NPH = 8;
  localparam logic [31:0] TBL [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                      4'b0100, 4'b1100, 4'b1000, 4'b1001};
`else
  localparam int NPH = 4;
  localparam logic [31:0] TBL [8] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001,
                                      4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif

  typedef struct packed {
    logic [7:0] px;
    logic [7:0] py;
    logic [3:0] cx;
    logic [3:0] cy;
    logic       lim;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step_valid = 1'b0;
  logic [1:0] dirx = 2'b00;
  logic [1:0] diry = 2'b00;
  logic       pen_down = 1'b0;

  logic       a_ready, b_ready, a_pwm, b_pwm, a_lim, b_lim;
  logic [3:0] a_cx, a_cy, b_cx, b_cy;
  logic [7:0] a_px, a_py, b_px, b_py;

  int n_pass = 0;
  int n_total = 0;

  int m_px [2];
  int m_py [2];
  int m_phx [2];
  int m_phy [2];
  bit m_lim [2];
  int pmax [2] = '{255, 3};
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  plotter_axis_driver #(.STEP_CYCLES(SC), .PEN_SETTLE(PS), .PWM_PERIOD(PP),
                        .PEN_UP_HIGH(UH), .PEN_DOWN_HIGH(DH), .POS_MAX(255)) u_a (
    .clk(clk), .rst(rst), .step_valid(step_valid), .dirx(dirx), .diry(diry),
    .pen_down(pen_down), .step_ready(a_ready), .coil_x(a_cx), .coil_y(a_cy),
    .pos_x(a_px), .pos_y(a_py), .servo_pwm(a_pwm), .limit_hit(a_lim));

  plotter_axis_driver #(.STEP_CYCLES(SC), .PEN_SETTLE(PS), .PWM_PERIOD(PP),
                        .PEN_UP_HIGH(UH), .PEN_DOWN_HIGH(DH), .POS_MAX(3)) u_b (
    .clk(clk), .rst(rst), .step_valid(step_valid), .dirx(dirx), .diry(diry),
    .pen_down(pen_down), .step_ready(b_ready), .coil_x(b_cx), .coil_y(b_cy),
    .pos_x(b_px), .pos_y(b_py), .servo_pwm(b_pwm), .limit_hit(b_lim));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mv(input logic [1:0] d);
    if (d == 2'b01) return 1;
    if (d == 2'b10) return -1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_px[d] = 0; m_py[d] = 0; m_phx[d] = 0; m_phy[d] = 0; m_lim[d] = 0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic model_step(input int d, input logic [1:0] dx, input logic [1:0] dy);
    exp_t e;
    int sx, sy;
    sx = mv(dx);
    sy = mv(dy);
    if ((sx == 1 && m_px[d] == pmax[d]) || (sx == -1 && m_px[d] == 0)) m_lim[d] = 1;
    else begin
      m_px[d] += sx;
      m_phx[d] = (m_phx[d] + sx + NPH) % NPH;
    end
    if ((sy == 1 && m_py[d] == pmax[d]) || (sy == -1 && m_py[d] == 0)) m_lim[d] = 1;
    else begin
      m_py[d] += sy;
      m_phy[d] = (m_phy[d] + sy + NPH) % NPH;
    end
    e.px = 8'(m_px[d]);
    e.py = 8'(m_py[d]);
    e.cx = TBL[m_phx[d]][3:0];
    e.cy = TBL[m_phy[d]][3:0];
    e.lim = m_lim[d];
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    chk("sb_a_nonempty", 32'(q_a.size() > 0), 1);
    chk("sb_b_nonempty", 32'(q_b.size() > 0), 1);
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("a_pos_x", a_px, e.px);
      chk("a_pos_y", a_py, e.py);
      chk("a_coil_x", a_cx, e.cx);
      chk("a_coil_y", a_cy, e.cy);
      chk("a_limit", a_lim, e.lim);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("b_pos_x", b_px, e.px);
      chk("b_pos_y", b_py, e.py);
      chk("b_coil_x", b_cx, e.cx);
      chk("b_coil_y", b_cy, e.cy);
      chk("b_limit", b_lim, e.lim);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(a_ready && b_ready) && n < 100) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(a_ready && b_ready), 1);
  endtask

  task automatic do_step(input logic [1:0] dx, input logic [1:0] dy);
    wait_ready();
    step_valid = 1'b1;
    dirx = dx;
    diry = dy;
    model_step(0, dx, dy);
    model_step(1, dx, dy);
    tick();
    step_valid = 1'b0;
    dirx = 2'b00;
    diry = 2'b00;
    check_sb();
    chk("ready_low_after_accept", a_ready, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pen_down = 1'b0;
    step_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    model_reset();
  endtask

  task automatic measure_pulse(output int w);
    int n = 0;
    w = 0;
    while (a_pwm && n < 40) begin tick(); n++; end
    n = 0;
    while (!a_pwm && n < 40) begin tick(); n++; end
    chk("pwm_rise_seen", a_pwm, 1);
    n = 0;
    while (a_pwm && n < 40) begin tick(); n++; w++; end
  endtask

  initial begin
    int n;
    int w;
    model_reset();
    repeat (2) tick();
    chk("rst_pos_x", a_px, 0);
    chk("rst_pos_y", a_py, 0);
    chk("rst_coil_x", a_cx, TBL[0]);
    chk("rst_coil_y", a_cy, TBL[0]);
    chk("rst_limit", a_lim, 0);
    chk("rst_servo", a_pwm, 0);
    chk("rst_ready", a_ready, 1);
    rst = 1'b1;
    tick();

    // single +X step and its hold time
    do_step(2'b01, 2'b00);
    chk("t1_pos_x", a_px, 1);
    chk("t1_coil_x", a_cx, TBL[1]);
    chk("t1_coil_y", a_cy, TBL[0]);
    n = 0;
    while (!a_ready && n < 50) begin n++; tick(); end
    chk("t1_hold_cycles", n, SC);

    // walk out and back; the POS_MAX=3 instance clips on the way
    for (int i = 0; i < 3; i++) do_step(2'b01, 2'b00);
    chk("t2_pos_x_top", a_px, 4);
    for (int i = 0; i < 4; i++) do_step(2'b10, 2'b00);
    chk("t2_pos_x_back", a_px, 0);

    // lower limit clip with the other axis still moving
    do_step(2'b10, 2'b01);
    chk("t3_pos_x_clip", a_px, 0);
    chk("t3_coil_x_clip", a_cx, TBL[0]);
    chk("t3_pos_y", a_py, 1);
    chk("t3_limit", a_lim, 1);
    do_step(2'b11, 2'b00);
    chk("t3_hold_pos_y", a_py, 1);

    // upper limit clip at POS_MAX=3
    do_reset();
    for (int i = 0; i < 3; i++) do_step(2'b01, 2'b00);
    chk("t3b_limit_clear", b_lim, 0);
    do_step(2'b01, 2'b01);
    chk("t3b_pos_x_clip", b_px, 3);
    chk("t3b_limit", b_lim, 1);
    chk("t3b_pos_y", b_py, 1);
    chk("t3b_a_unclipped", a_px, 4);

    // pen change races a step
    measure_pulse(w);
    chk("t4_pwm_up_width", w, UH);
    wait_ready();
    pen_down = 1'b1;
    step_valid = 1'b1;
    dirx = 2'b01;
    #1;
    chk("t4_ready_low_on_pen", a_ready, 0);
    tick();
    chk("t4_no_step_pos", a_px, 4);
    n = 0;
    while (!a_ready && n < 50) begin n++; tick(); end
    chk("t4_settle_cycles", n, PS);
    model_step(0, 2'b01, 2'b00);
    model_step(1, 2'b01, 2'b00);
    tick();
    step_valid = 1'b0;
    dirx = 2'b00;
    check_sb();
    measure_pulse(w);
    measure_pulse(w);
    chk("t4_pwm_down_width", w, DH);

    // asynchronous reset in the middle of a hold
    do_reset();
    do_step(2'b10, 2'b00);
    do_step(2'b01, 2'b00);
    do_step(2'b01, 2'b00);
    chk("t5_pre_pos_x", a_px, 2);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("t5_pos_x", a_px, 0);
    chk("t5_coil_x", a_cx, TBL[0]);
    chk("t5_limit", a_lim, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_ready", a_ready, 1);
    model_reset();
    do_step(2'b01, 2'b01);

`ifdef PLOTTER_HALF_STEP_EN
    do_reset();
    do_step(2'b01, 2'b00);
    chk("t6_coil_1", a_cx, 4'b0011);
    do_step(2'b01, 2'b00);
    chk("t6_coil_2", a_cx, 4'b0010);
    do_step(2'b01, 2'b00);
    chk("t6_coil_3", a_cx, 4'b0110);
    chk("t6_pos_x", a_px, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/plotter_axis_driver.md
Name: plotter_axis_driver

Overview:
- Consumer end of the draw_line step interface: accepts per-step direction codes (dirx/diry) plus the pen_down level and turns them into coil phase patterns for the X and Y unipolar steppers.
- Also produces the pen servo PWM.
- Tracks absolute X/Y position and paces steps, so the sequencer and line generator see a ready/valid handshake instead of raw motor timing.

Parameters:
- STEP_CYCLES, 200000, clk cycles the coils are held after an accepted step (step period).
- PEN_SETTLE, 50000000, clk cycles of wait after a pen level change before steps are accepted again.
- PWM_PERIOD, 2000000, servo PWM period in clk cycles.
- PEN_UP_HIGH, 100000, PWM high time when pen is up.
- PEN_DOWN_HIGH, 200000, PWM high time when pen is down.
- POS_MAX, 255, upper position limit per axis; lower limit is 0.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- step_valid, input, 1, step command present.
- dirx, input, 2, X direction: 01 = +1, 10 = -1, 00/11 = hold.
- diry, input, 2, Y direction, same encoding as dirx.
- pen_down, input, 1, requested pen level (1 = down).
- step_ready, output, 1, driver can accept a step this cycle.
- coil_x, output, 4, X stepper coil drive.
- coil_y, output, 4, Y stepper coil drive.
- pos_x, output, 8, current X position.
- pos_y, output, 8, current Y position.
- servo_pwm, output, 1, pen servo PWM.
- limit_hit, output, 1, sticky: a step was clipped at a limit.

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE, counters 0, phase_x = phase_y = 0, pos_x = pos_y = 0.
  - pen_q = 0; limit_hit = 0; servo_pwm = 0.
  - coil_x = coil_y = pattern of phase 0 (4'b0011).
  - Reset mid-step or mid-settle abandons the operation with no partial update.
- step_ready = (state == IDLE) && (pen_down == pen_q). It is combinational from registered state and the pen_down input.
- A step is accepted when step_valid && step_ready on a rising clk edge (cycle N).
  - Cycle N+1: phase, position and coil outputs updated; state becomes HOLD; step_ready low.
- HOLD counts STEP_CYCLES cycles, then returns to IDLE. step_ready is high again at cycle N+1+STEP_CYCLES.
- A step with both axes at hold (00/11) is still accepted and still costs STEP_CYCLES; phases and positions are unchanged.
- Per-axis update:
  - +1: phase increments mod 4 and pos increments.
  - -1: phase decrements mod 4 and pos decrements.
- Full-step coil table, phase 0..3: 0011, 0110, 1100, 1001.
- Limit boundary:
  - +1 at pos == POS_MAX, or -1 at pos == 0: that axis neither moves phase nor changes pos, and limit_hit sets.
  - The other axis still moves normally.
  - limit_hit clears only on reset.
- Pen handling:
  - In IDLE, if pen_down != pen_q: pen_q <= pen_down and state goes to PEN_WAIT. step_valid that cycle is not accepted.
  - PEN_WAIT counts PEN_SETTLE cycles, then returns to IDLE.
  - pen_down toggling during HOLD or PEN_WAIT is ignored until IDLE is re-entered.
- State machine:
  - IDLE -> HOLD on accepted step.
  - IDLE -> PEN_WAIT on pen mismatch (pen mismatch has priority over step_valid).
  - HOLD -> IDLE when count == STEP_CYCLES-1.
  - PEN_WAIT -> IDLE when count == PEN_SETTLE-1.
  - Count resets to 0 on every state entry.
- Servo PWM:
  - Free-running counter 0..PWM_PERIOD-1, wrapping to 0.
  - servo_pwm = (pwm_cnt < (pen_q ? PEN_DOWN_HIGH : PEN_UP_HIGH)), registered.
  - The new high time takes effect on the next PWM cycle boundary (pwm_cnt wrap), never mid-pulse.
- Counter widths: 27 bits for step/settle/pwm counters. Parameters must fit in 27 bits.

Optional Feature:
- Macro: PLOTTER_HALF_STEP_EN.
- Defined:
  - Phase counters are 3 bits, mod 8.
  - Half-step coil table, phase 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001. Reset pattern is 0001.
  - Each accepted step advances one half-step; pos still changes by 1 per step.
- Undefined: 4-phase full-step table above.

Test Plan:
1. Small parameters (STEP_CYCLES=4, PEN_SETTLE=6, PWM_PERIOD=10, PEN_UP_HIGH=2, PEN_DOWN_HIGH=5). Release reset, step_valid with dirx=01, diry=00 -> next cycle pos_x=1, coil_x=0110, coil_y=0011; step_ready low for exactly 4 cycles, then high.
2. Four steps dirx=01 then four steps dirx=10 -> coil_x sequence 0110, 1100, 1001, 0011, then 1001, 1100, 0110, 0011; pos_x goes 4 and then back to 0.
3. At pos_x=0, step dirx=10, diry=01 -> pos_x stays 0, coil_x unchanged, limit_hit=1, pos_y=1. Same check with POS_MAX=3 at pos_x=3 and dirx=01.
4. Raise pen_down with step_valid high in the same cycle -> step_ready=0, no step accepted; PEN_WAIT lasts 6 cycles; servo_pwm high time becomes 5 from the next PWM wrap; the step is then accepted.
5. Assert rst low mid-HOLD after pos_x=2 -> pos_x=0, coils 0011, limit_hit=0, step_ready=1 immediately after release. Assertion must be asynchronous, checked between clock edges.
6. With PLOTTER_HALF_STEP_EN defined, three +X steps -> coil_x 0011, 0010, 0110 and pos_x=3.
